// File: rtl/linefill_rsp_packer_if.sv
// linefill_rsp_packer_if: context command, downstream response, packed linefill
// and error signals between the packer and its neighbours.
interface linefill_rsp_packer_if #(
    parameter int RSP_ID_WIDTH  = 4,
    parameter int DB_ID_WIDTH   = 3,
    parameter int ROB_ID_WIDTH  = 6,
    parameter int DS_DATA_WIDTH = 512,
    parameter int LF_DATA_WIDTH = 1024
);
    logic                     cmd_vld;
    logic                     cmd_rdy;
    logic [RSP_ID_WIDTH-1:0]  cmd_rsp_id;
    logic [DB_ID_WIDTH-1:0]   cmd_db_entry_id;
    logic [ROB_ID_WIDTH-1:0]  cmd_rob_entry_id;
    logic                     rsp_vld;
    logic                     rsp_rdy;
    logic [RSP_ID_WIDTH-1:0]  rsp_id;
    logic [DS_DATA_WIDTH-1:0] rsp_data;
    logic                     rsp_last;
    logic                     lf_vld;
    logic                     lf_rdy;
    logic [LF_DATA_WIDTH-1:0] lf_data;
    logic [DB_ID_WIDTH-1:0]   lf_db_entry_id;
    logic [ROB_ID_WIDTH-1:0]  lf_rob_entry_id;
    logic                     lf_last;
    logic                     err_vld;
    logic [1:0]               err_code;

    modport slave (
        input  cmd_vld, cmd_rsp_id, cmd_db_entry_id, cmd_rob_entry_id,
        input  rsp_vld, rsp_id, rsp_data, rsp_last, lf_rdy,
        output cmd_rdy, rsp_rdy, lf_vld, lf_data, lf_db_entry_id, lf_rob_entry_id,
        output lf_last, err_vld, err_code
    );

    modport master (
        output cmd_vld, cmd_rsp_id, cmd_db_entry_id, cmd_rob_entry_id,
        output rsp_vld, rsp_id, rsp_data, rsp_last, lf_rdy,
        input  cmd_rdy, rsp_rdy, lf_vld, lf_data, lf_db_entry_id, lf_rob_entry_id,
        input  lf_last, err_vld, err_code
    );
endinterface

// File: rtl/linefill_rsp_packer.sv
// linefill_rsp_packer: matches 512-bit downstream beats to registered linefill
// contexts by response ID and packs beat pairs into the 1024-bit linefill stream.
module linefill_rsp_packer #(
    parameter int RSP_ID_WIDTH  = 4,
    parameter int DB_ID_WIDTH   = 3,
    parameter int ROB_ID_WIDTH  = 6,
    parameter int DS_DATA_WIDTH = 512,
    parameter int LF_DATA_WIDTH = 1024
) (
    input logic                clk,
    input logic                rst,
    linefill_rsp_packer_if.slave io
);
    localparam int NCTX = 2 ** RSP_ID_WIDTH;

    typedef enum logic [1:0] {IDLE, LO, HI} state_t;

    state_t                                  state_q, state_d;
    logic [NCTX-1:0]                         ctx_vld_q, ctx_vld_d;
    logic [NCTX-1:0][DB_ID_WIDTH-1:0]        ctx_db_q, ctx_db_d;
    logic [NCTX-1:0][ROB_ID_WIDTH-1:0]       ctx_rob_q, ctx_rob_d;
    logic [RSP_ID_WIDTH-1:0]                 cur_id_q, cur_id_d;
    logic [2:0]                              ds_cnt_q, ds_cnt_d;
    logic [DS_DATA_WIDTH-1:0]                lo_buf_q, lo_buf_d;
    logic                                    lf_vld_q, lf_vld_d;
    logic [LF_DATA_WIDTH-1:0]                lf_data_q, lf_data_d;
    logic [DB_ID_WIDTH-1:0]                  lf_db_q, lf_db_d;
    logic [ROB_ID_WIDTH-1:0]                 lf_rob_q, lf_rob_d;
    logic                                    lf_last_q, lf_last_d;
    logic [RSP_ID_WIDTH-1:0]                 lf_id_q, lf_id_d;
    logic                                    err_vld_q, err_vld_d;
    logic [1:0]                              err_code_q, err_code_d;

    logic cmd_hs, rsp_hs, lf_hs, id_bad, line_end;

    assign io.cmd_rdy         = !ctx_vld_q[io.cmd_rsp_id];
    // In HI the output register may only be overwritten once its beat has left.
    assign io.rsp_rdy         = (state_q != HI) || !lf_vld_q || io.lf_rdy;
    assign io.lf_vld          = lf_vld_q;
    assign io.lf_data         = lf_data_q;
    assign io.lf_db_entry_id  = lf_db_q;
    assign io.lf_rob_entry_id = lf_rob_q;
    assign io.lf_last         = lf_last_q;
    assign io.err_vld         = err_vld_q;
    assign io.err_code        = err_code_q;

    assign cmd_hs   = io.cmd_vld && io.cmd_rdy;
    assign rsp_hs   = io.rsp_vld && io.rsp_rdy;
    assign lf_hs    = lf_vld_q && io.lf_rdy;
    assign id_bad   = (state_q == IDLE) ? !ctx_vld_q[io.rsp_id] : (io.rsp_id != cur_id_q);
    assign line_end = ds_cnt_q == 3'd7;

    always_comb begin
        state_d    = state_q;
        ctx_vld_d  = ctx_vld_q;
        ctx_db_d   = ctx_db_q;
        ctx_rob_d  = ctx_rob_q;
        cur_id_d   = cur_id_q;
        ds_cnt_d   = ds_cnt_q;
        lo_buf_d   = lo_buf_q;
        lf_vld_d   = lf_vld_q && !io.lf_rdy;
        lf_data_d  = lf_data_q;
        lf_db_d    = lf_db_q;
        lf_rob_d   = lf_rob_q;
        lf_last_d  = lf_last_q;
        lf_id_d    = lf_id_q;
        err_vld_d  = 1'b0;
        err_code_d = 2'd0;
        // The context stays live until its final packed beat is taken by the buffer.
        if (lf_hs && lf_last_q)
            ctx_vld_d[lf_id_q] = 1'b0;
        if (cmd_hs) begin
            ctx_vld_d[io.cmd_rsp_id] = 1'b1;
            ctx_db_d[io.cmd_rsp_id]  = io.cmd_db_entry_id;
            ctx_rob_d[io.cmd_rsp_id] = io.cmd_rob_entry_id;
        end
        if (rsp_hs) begin
            if (id_bad) begin
                err_vld_d  = 1'b1;
                err_code_d = (state_q == IDLE) ? 2'd1 : 2'd2;
            end else begin
                err_vld_d  = io.rsp_last != line_end;
                err_code_d = err_vld_d ? 2'd3 : 2'd0;
                ds_cnt_d   = ds_cnt_q + 3'd1;
                if (state_q == HI) begin
                    lf_vld_d  = 1'b1;
                    lf_data_d = {io.rsp_data, lo_buf_q};
                    lf_db_d   = ctx_db_q[cur_id_q];
                    lf_rob_d  = ctx_rob_q[cur_id_q];
                    lf_last_d = line_end;
                    lf_id_d   = cur_id_q;
                    state_d   = line_end ? IDLE : LO;
                end else begin
                    lo_buf_d = io.rsp_data;
                    cur_id_d = io.rsp_id;
                    state_d  = HI;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ctx_vld_q  <= '0;
            ctx_db_q   <= '0;
            ctx_rob_q  <= '0;
            cur_id_q   <= '0;
            ds_cnt_q   <= '0;
            lo_buf_q   <= '0;
            lf_vld_q   <= 1'b0;
            lf_data_q  <= '0;
            lf_db_q    <= '0;
            lf_rob_q   <= '0;
            lf_last_q  <= 1'b0;
            lf_id_q    <= '0;
            err_vld_q  <= 1'b0;
            err_code_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            ctx_vld_q  <= ctx_vld_d;
            ctx_db_q   <= ctx_db_d;
            ctx_rob_q  <= ctx_rob_d;
            cur_id_q   <= cur_id_d;
            ds_cnt_q   <= ds_cnt_d;
            lo_buf_q   <= lo_buf_d;
            lf_vld_q   <= lf_vld_d;
            lf_data_q  <= lf_data_d;
            lf_db_q    <= lf_db_d;
            lf_rob_q   <= lf_rob_d;
            lf_last_q  <= lf_last_d;
            lf_id_q    <= lf_id_d;
            err_vld_q  <= err_vld_d;
            err_code_q <= err_code_d;
        end
    end
endmodule

// File: tb/tb_linefill_rsp_packer.sv
// tb_linefill_rsp_packer: table vectors, directed corner sequences and random
// lines checked against a line-level model of the packed output and error stream.
module tb_linefill_rsp_packer;
    localparam int RW = 4, DW = 3, OW = 6, SW = 512, LW = 1024;

    typedef logic [SW-1:0] word_t;
    typedef struct packed {
        logic [LW-1:0] data;
        logic [DW-1:0] db;
        logic [OW-1:0] rob;
        logic          last;
    } beat_t;
    typedef struct {
        logic [RW-1:0] id;
        logic          reg_ctx;
        logic [DW-1:0] db;
        logic [OW-1:0] rob;
        int            base;
        int            exp_err;
        int            exp_beats;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    logic force_low = 1'b0;
    logic rand_rdy = 1'b0;

    beat_t      exp_q[$], obs_q[$];
    logic [1:0] exp_err_q[$], obs_err_q[$];
    int         lf_cyc_q[$], err_cyc_q[$];

    linefill_rsp_packer_if #(.RSP_ID_WIDTH(RW), .DB_ID_WIDTH(DW), .ROB_ID_WIDTH(OW),
                             .DS_DATA_WIDTH(SW), .LF_DATA_WIDTH(LW)) bus ();

    linefill_rsp_packer #(.RSP_ID_WIDTH(RW), .DB_ID_WIDTH(DW), .ROB_ID_WIDTH(OW),
                          .DS_DATA_WIDTH(SW), .LF_DATA_WIDTH(LW)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        bus.lf_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.lf_rdy = force_low ? 1'b0 : rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Records handshaken beats and error pulses; a stalled beat must hold until taken.
    initial begin
        beat_t b, prev_b;
        logic  prev_stall;
        prev_stall = 1'b0;
        prev_b     = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                b = {bus.lf_data, bus.lf_db_entry_id, bus.lf_rob_entry_id, bus.lf_last};
                if (prev_stall) begin
                    n_vec++;
                    if (!bus.lf_vld || b != prev_b) begin
                        n_err++;
                        $display("FAIL stall_hold: vld=%0b db=%0d rob=%0d last=%0b lo=%h required vld=1 db=%0d rob=%0d last=%0b lo=%h",
                                 bus.lf_vld, b.db, b.rob, b.last, b.data[63:0], prev_b.db, prev_b.rob, prev_b.last, prev_b.data[63:0]);
                    end
                end
                prev_stall = bus.lf_vld && !bus.lf_rdy;
                prev_b     = b;
                if (bus.lf_vld && bus.lf_rdy) begin
                    obs_q.push_back(b);
                    lf_cyc_q.push_back(cyc);
                end
                if (bus.err_vld) begin
                    obs_err_q.push_back(bus.err_code);
                    err_cyc_q.push_back(cyc);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, required completion");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_cmd(input logic [RW-1:0] id, input logic [DW-1:0] db, input logic [OW-1:0] rob);
        logic ok;
        int   n;
        n = 0;
        bus.cmd_vld = 1'b1;
        bus.cmd_rsp_id = id;
        bus.cmd_db_entry_id = db;
        bus.cmd_rob_entry_id = rob;
        do begin
            @(negedge clk);
            ok = bus.cmd_rdy;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 400);
        bus.cmd_vld = 1'b0;
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL cmd_timeout: id=%0d cmd_rdy got 0 required 1 within 400 cycles", id);
        end
    endtask

    task automatic send_beat(input logic [RW-1:0] id, input word_t data, input logic last, output int hs_cyc);
        logic ok;
        int   n;
        n = 0;
        bus.rsp_vld = 1'b1;
        bus.rsp_id = id;
        bus.rsp_data = data;
        bus.rsp_last = last;
        do begin
            @(negedge clk);
            ok = bus.rsp_rdy;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 400);
        bus.rsp_vld = 1'b0;
        hs_cyc = cyc;
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL rsp_timeout: id=%0d rsp_rdy got 0 required 1 within 400 cycles", id);
        end
    endtask

    // Model: a line of eight words becomes four pairs, first-received word in the low half.
    task automatic expect_line(input logic [DW-1:0] db, input logic [OW-1:0] rob, input word_t w [8]);
        beat_t b;
        for (int k = 0; k < 4; k++) begin
            b.data = {w[2*k+1], w[2*k]};
            b.db   = db;
            b.rob  = rob;
            b.last = (k == 3);
            exp_q.push_back(b);
        end
    endtask

    task automatic send_line(input logic [RW-1:0] id, input word_t w [8], input logic bad_last,
                             input int sw_pos, input logic [RW-1:0] sw_id, input logic gaps);
        int   hc;
        logic lst;
        for (int i = 0; i < 8; i++) begin
            if (i == sw_pos) begin
                send_beat(sw_id, '0, 1'b0, hc);
                exp_err_q.push_back(2'd2);
            end
            lst = bad_last ? (i == 2) : (i == 7);
            if (lst != (i == 7))
                exp_err_q.push_back(2'd3);
            if (gaps)
                tick($urandom_range(0, 2));
            send_beat(id, w[i], lst, hc);
        end
    endtask

    task automatic drain_check(input string name, output int nbeats, output int first_err);
        beat_t e, o;
        int    n;
        n = 0;
        while (obs_q.size() < exp_q.size() && n < 500) begin
            tick(1);
            n++;
        end
        tick(4);
        nbeats    = obs_q.size();
        first_err = obs_err_q.size() > 0 ? int'(obs_err_q[0]) : 0;
        chk({name, "_beat_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_vec++;
            if (o != e) begin
                n_err++;
                $display("FAIL %s_beat: lo=%h hi=%h db=%0d rob=%0d last=%0b required lo=%h hi=%h db=%0d rob=%0d last=%0b",
                         name, o.data[63:0], o.data[575:512], o.db, o.rob, o.last,
                         e.data[63:0], e.data[575:512], e.db, e.rob, e.last);
            end
        end
        chk({name, "_err_count"}, 64'(obs_err_q.size()), 64'(exp_err_q.size()));
        while (exp_err_q.size() > 0 && obs_err_q.size() > 0)
            chk({name, "_err_code"}, 64'(obs_err_q.pop_front()), 64'(exp_err_q.pop_front()));
        exp_q.delete();
        obs_q.delete();
        exp_err_q.delete();
        obs_err_q.delete();
        lf_cyc_q.delete();
        err_cyc_q.delete();
    endtask

    initial begin
        vec_t  tbl [6];
        word_t w [8];
        word_t w2 [8];
        int    hc, nb, fe, gap, ecyc;
        logic [RW-1:0] rid;

        rst = 1'b1;
        bus.cmd_vld = 1'b0;
        bus.cmd_rsp_id = '0;
        bus.cmd_db_entry_id = '0;
        bus.cmd_rob_entry_id = '0;
        bus.rsp_vld = 1'b0;
        bus.rsp_id = '0;
        bus.rsp_data = '0;
        bus.rsp_last = 1'b0;
        tick(3);
        chk("rst_lf_vld", bus.lf_vld, 0);
        chk("rst_err_vld", bus.err_vld, 0);
        chk("rst_err_code", bus.err_code, 0);
        chk("rst_lf_data_zero", bus.lf_data == '0, 1);
        chk("rst_lf_db", bus.lf_db_entry_id, 0);
        chk("rst_lf_rob", bus.lf_rob_entry_id, 0);
        chk("rst_lf_last", bus.lf_last, 0);
        chk("rst_rsp_rdy", bus.rsp_rdy, 1);
        for (int i = 0; i < 16; i++) begin
            bus.cmd_rsp_id = 4'(i);
            #1;
            chk("rst_cmd_rdy", bus.cmd_rdy, 1);
        end
        rst = 1'b0;
        tick(2);

        tbl[0] = '{4'd5,  1'b1, 3'd2, 6'd17, 0,      0, 4};
        tbl[1] = '{4'd5,  1'b1, 3'd7, 6'd63, 100,    0, 4};
        tbl[2] = '{4'd9,  1'b0, 3'd0, 6'd0,  55,     1, 0};
        tbl[3] = '{4'd0,  1'b1, 3'd0, 6'd0,  'h20,   0, 4};
        tbl[4] = '{4'd15, 1'b1, 3'd5, 6'd42, 'h300,  0, 4};
        tbl[5] = '{4'd12, 1'b0, 3'd0, 6'd0,  7,      1, 0};
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 8; j++)
                w[j] = word_t'(tbl[i].base + j);
            if (tbl[i].reg_ctx) begin
                send_cmd(tbl[i].id, tbl[i].db, tbl[i].rob);
                bus.cmd_rsp_id = tbl[i].id;
                #1;
                chk("tbl_ctx_busy", bus.cmd_rdy, 0);
                expect_line(tbl[i].db, tbl[i].rob, w);
                send_line(tbl[i].id, w, 1'b0, -1, '0, 1'b0);
            end else begin
                send_beat(tbl[i].id, w[0], 1'b0, hc);
                exp_err_q.push_back(2'd1);
                tick(2);
                ecyc = err_cyc_q.size() > 0 ? err_cyc_q[0] : -1;
                chk("unk_err_cycle", 64'(ecyc), 64'(hc));
                chk("unk_rsp_rdy_idle", bus.rsp_rdy, 1);
            end
            drain_check("tbl", nb, fe);
            chk("tbl_beats", 64'(nb), 64'(tbl[i].exp_beats));
            chk("tbl_err", 64'(fe), 64'(tbl[i].exp_err));
            bus.cmd_rsp_id = tbl[i].id;
            #1;
            chk("tbl_ctx_free", bus.cmd_rdy, 1);
        end

        // Backpressure: hold the first packed beat for five cycles.
        for (int j = 0; j < 8; j++)
            w[j] = word_t'(j);
        send_cmd(4'd5, 3'd2, 6'd17);
        expect_line(3'd2, 6'd17, w);
        force_low = 1'b1;
        fork
            send_line(4'd5, w, 1'b0, -1, '0, 1'b0);
            begin
                int n;
                n = 0;
                @(negedge clk);
                while (!bus.lf_vld && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    if (k >= 1)
                        chk("bp_rsp_rdy_hi", bus.rsp_rdy, 0);
                end
                force_low = 1'b0;
            end
        join
        drain_check("bp", nb, fe);

        // Back-to-back lines; context 2 registered while line 1 is streaming.
        for (int j = 0; j < 8; j++) begin
            for (int k = 0; k < 16; k++) begin
                w[j][k*32 +: 32]  = $urandom;
                w2[j][k*32 +: 32] = $urandom;
            end
        end
        send_cmd(4'd1, 3'd3, 6'd33);
        expect_line(3'd3, 6'd33, w);
        expect_line(3'd6, 6'd44, w2);
        fork
            send_line(4'd1, w, 1'b0, -1, '0, 1'b0);
            begin
                tick(2);
                send_cmd(4'd2, 3'd6, 6'd44);
            end
        join
        send_line(4'd2, w2, 1'b0, -1, '0, 1'b0);
        tick(6);
        gap = lf_cyc_q.size() >= 5 ? lf_cyc_q[4] - lf_cyc_q[3] : -1;
        chk("b2b_gap", 64'(gap), 2);
        drain_check("b2b", nb, fe);

        // Foreign ID mid-line, then misplaced rsp_last.
        for (int j = 0; j < 8; j++)
            w[j] = word_t'('h500 + j);
        send_cmd(4'd3, 3'd1, 6'd9);
        expect_line(3'd1, 6'd9, w);
        send_line(4'd3, w, 1'b0, 3, 4'd4, 1'b0);
        drain_check("idsw", nb, fe);
        chk("idsw_code", 64'(fe), 2);
        send_cmd(4'd7, 3'd4, 6'd50);
        expect_line(3'd4, 6'd50, w);
        send_line(4'd7, w, 1'b1, -1, '0, 1'b0);
        drain_check("badlast", nb, fe);
        chk("badlast_code", 64'(fe), 3);

        // Reset in the middle of a line.
        send_cmd(4'd6, 3'd5, 6'd20);
        for (int i = 0; i < 4; i++)
            send_beat(4'd6, word_t'('h900 + i), 1'b0, hc);
        chk("rst_mid_pre_vld", bus.lf_vld, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_lf_vld", bus.lf_vld, 0);
        bus.cmd_rsp_id = 4'd6;
        #1;
        chk("rst_mid_ctx_clear", bus.cmd_rdy, 1);
        tick(2);
        rst = 1'b0;
        exp_q.delete();
        obs_q.delete();
        exp_err_q.delete();
        obs_err_q.delete();
        lf_cyc_q.delete();
        err_cyc_q.delete();
        tick(2);
        chk("rst_mid_no_beat", 64'(obs_q.size()), 0);
        for (int j = 0; j < 8; j++)
            w[j] = word_t'(j);
        send_cmd(4'd5, 3'd2, 6'd17);
        expect_line(3'd2, 6'd17, w);
        send_line(4'd5, w, 1'b0, -1, '0, 1'b0);
        drain_check("post_rst", nb, fe);

        // Random lines with random buffer readiness, gaps and injected faults.
        rand_rdy = 1'b1;
        for (int l = 0; l < 40; l++) begin
            if ($urandom_range(0, 3) == 0) begin
                drain_check("rnd", nb, fe);
                send_beat(4'($urandom_range(0, 15)), '0, 1'b0, hc);
                exp_err_q.push_back(2'd1);
            end
            rid = 4'($urandom_range(0, 15));
            for (int j = 0; j < 8; j++)
                for (int k = 0; k < 16; k++)
                    w[j][k*32 +: 32] = $urandom;
            send_cmd(rid, 3'(l), 6'($urandom_range(0, 63)));
            expect_line(3'(l), bus.cmd_rob_entry_id, w);
            send_line(rid, w, 1'($urandom_range(0, 4) == 0),
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : -1,
                      rid ^ 4'($urandom_range(1, 15)), 1'b1);
        end
        drain_check("rnd_final", nb, fe);
        rand_rdy = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
